// File: rtl/rvfi_trace_pkg.sv
// rvfi_trace_pkg: shared types for the RVFI trace capture path.
// Holds the retire record layout and the order-number width.
package rvfi_trace_pkg;

  localparam int ORDER_W = 64;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic [31:0]        pc;
    logic               trap;
    logic               gap;
    logic [4:0]         rd_addr;
    logic [31:0]        rd_wdata;
    logic [31:0]        mem_addr;
    logic [3:0]         rmask;
    logic [3:0]         wmask;
    logic [31:0]        mem_data;
  } rvfi_rec_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: DEPTH-entry first-word-fall-through record FIFO.
// Ports: push/wdata in, pop/rdata out, level/full/empty status.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  rvfi_rec_t                wdata,
  input  logic                     pop,
  output rvfi_rec_t                rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rvfi_rec_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_wr, do_rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign do_rd = pop & ~empty;
  // A push into a full FIFO is legal only when a pop frees a slot.
  assign do_wr = push & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    level_d  = level_q;
    if (do_wr && !do_rd) level_d = level_q + LW'(1);
    if (do_rd && !do_wr) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/rvfi_trace_capture.sv
// rvfi_trace_capture: turns core debug signals into ordered RVFI
// retire records, filters by PC window, buffers and drains them.
// Ports: core debug inputs, filter window, t_* valid/ready record
// output, FIFO level/afull and saturating drop_count.
module rvfi_trace_capture
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter bit MEM_EN      = 1'b1,
  parameter int DROP_W      = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   launch_next_insn,
  input  logic                   trap,
  input  logic                   dbg_valid_insn,
  input  logic [31:0]            dbg_insn_opcode,
  input  logic [31:0]            dbg_insn_addr,
  input  logic [4:0]             latched_rd,
  input  logic                   irq_state,
  input  logic                   cpuregs_write,
  input  logic [31:0]            cpuregs_wrdata,
  input  logic                   dbg_mem_instr,
  input  logic                   dbg_mem_valid,
  input  logic                   dbg_mem_ready,
  input  logic [31:0]            dbg_mem_addr,
  input  logic [31:0]            dbg_mem_rdata,
  input  logic [31:0]            dbg_mem_wdata,
  input  logic [3:0]             dbg_mem_wstrb,
  input  logic                   filt_en,
  input  logic [31:0]            filt_lo,
  input  logic [31:0]            filt_hi,
  output logic                   t_valid,
  input  logic                   t_ready,
  output logic [63:0]            t_order,
  output logic [31:0]            t_insn,
  output logic [31:0]            t_pc,
  output logic                   t_trap,
  output logic                   t_gap,
  output logic [4:0]             t_rd_addr,
  output logic [31:0]            t_rd_wdata,
  output logic [31:0]            t_mem_addr,
  output logic [3:0]             t_mem_rmask,
  output logic [3:0]             t_mem_wmask,
  output logic [31:0]            t_mem_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   afull,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic               ret1_q, ret1_d;
  logic               trap1_q, trap1_d;
  logic [31:0]        insn1_q, insn1_d;
  logic [31:0]        pc1_q, pc1_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic [31:0]        rd_wdata_q, rd_wdata_d;
  logic [31:0]        mem_addr_q;
  logic [3:0]         mem_rmask_q;
  logic [3:0]         mem_wmask_q;
  logic [31:0]        mem_rdata_q;
  logic [31:0]        mem_wdata_q;
  logic [ORDER_W-1:0] order_q, order_d;
  logic               gap_q, gap_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic      rd_cap, in_win, push_req, pop, drop, accept;
  logic      f_full, f_empty;
  rvfi_rec_t rec, head, out_rec;

  assign ret1_d  = resetn & (launch_next_insn | trap) & dbg_valid_insn;
  assign trap1_d = trap;
  assign insn1_d = dbg_insn_opcode;
  assign pc1_d   = dbg_insn_addr;

  assign rd_cap = cpuregs_write & ~irq_state;

  // Staged fields belong to one record; wipe them once it forms,
  // but a capture in that same cycle belongs to the next record.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    if (rd_cap) begin
      rd_addr_d  = latched_rd;
      rd_wdata_d = (latched_rd != 5'd0) ? cpuregs_wrdata : 32'd0;
    end else if (ret1_q) begin
      rd_addr_d  = '0;
      rd_wdata_d = '0;
    end
  end

  generate
    if (MEM_EN) begin : g_mem
      logic [31:0] addr_d, rdata_d, wdata_d;
      logic [3:0]  rmask_d, wmask_d;

      always_comb begin
        addr_d  = mem_addr_q;
        rmask_d = mem_rmask_q;
        wmask_d = mem_wmask_q;
        rdata_d = mem_rdata_q;
        wdata_d = mem_wdata_q;
        if (dbg_mem_instr) begin
          addr_d  = '0;
          rmask_d = '0;
          wmask_d = '0;
          rdata_d = '0;
          wdata_d = '0;
        end else if (dbg_mem_valid && dbg_mem_ready) begin
          addr_d  = dbg_mem_addr;
          wmask_d = dbg_mem_wstrb;
          rmask_d = (dbg_mem_wstrb != 4'd0) ? 4'h0 : 4'hF;
          rdata_d = dbg_mem_rdata;
          wdata_d = dbg_mem_wdata;
        end else if (ret1_q) begin
          addr_d  = '0;
          rmask_d = '0;
          wmask_d = '0;
          rdata_d = '0;
          wdata_d = '0;
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          mem_addr_q  <= '0;
          mem_rmask_q <= '0;
          mem_wmask_q <= '0;
          mem_rdata_q <= '0;
          mem_wdata_q <= '0;
        end else begin
          mem_addr_q  <= addr_d;
          mem_rmask_q <= rmask_d;
          mem_wmask_q <= wmask_d;
          mem_rdata_q <= rdata_d;
          mem_wdata_q <= wdata_d;
        end
      end
    end else begin : g_nomem
      assign mem_addr_q  = '0;
      assign mem_rmask_q = '0;
      assign mem_wmask_q = '0;
      assign mem_rdata_q = '0;
      assign mem_wdata_q = '0;
    end
  endgenerate

  always_comb begin
    rec          = '0;
    rec.order    = order_q;
    rec.insn     = insn1_q;
    rec.pc       = pc1_q;
    rec.trap     = trap1_q;
    rec.gap      = gap_q;
    rec.rd_addr  = rd_addr_q;
    rec.rd_wdata = rd_wdata_q;
    rec.mem_addr = mem_addr_q;
    rec.rmask    = mem_rmask_q;
    rec.wmask    = mem_wmask_q;
    rec.mem_data = (mem_wmask_q != 4'd0) ? mem_wdata_q : mem_rdata_q;
  end

  assign in_win   = ~filt_en | ((pc1_q >= filt_lo) & (pc1_q <= filt_hi));
  assign push_req = ret1_q & in_win;
  assign pop      = t_valid & t_ready;
  assign drop     = push_req & f_full & ~pop;
  assign accept   = push_req & ~drop;

  always_comb begin
    // Every retire consumes an order number, kept or not.
    order_d = order_q + ORDER_W'(ret1_q);
    gap_d   = gap_q;
    if (drop)        gap_d = 1'b1;
    else if (accept) gap_d = 1'b0;
    drop_d = drop_q;
    if (drop && !(&drop_q)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ret1_q     <= 1'b0;
      trap1_q    <= 1'b0;
      insn1_q    <= '0;
      pc1_q      <= '0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      order_q    <= '0;
      gap_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      ret1_q     <= ret1_d;
      trap1_q    <= trap1_d;
      insn1_q    <= insn1_d;
      pc1_q      <= pc1_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      order_q    <= order_d;
      gap_q      <= gap_d;
      drop_q     <= drop_d;
    end
  end

  rvfi_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (resetn),
    .push  (accept),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (f_full),
    .empty (f_empty)
  );

  assign t_valid = ~f_empty;
  // Hide stale storage while empty so outputs read as zero.
  assign out_rec = t_valid ? head : '0;

  assign t_order     = out_rec.order;
  assign t_insn      = out_rec.insn;
  assign t_pc        = out_rec.pc;
  assign t_trap      = out_rec.trap;
  assign t_gap       = out_rec.gap;
  assign t_rd_addr   = out_rec.rd_addr;
  assign t_rd_wdata  = out_rec.rd_wdata;
  assign t_mem_addr  = out_rec.mem_addr;
  assign t_mem_rmask = out_rec.rmask;
  assign t_mem_wmask = out_rec.wmask;
  assign t_mem_data  = out_rec.mem_data;
  assign afull       = (level >= LW'(AFULL_LEVEL));
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_rvfi_trace_capture.sv
// tb_rvfi_trace_capture: directed bench for rvfi_trace_capture.
// Covers reset, rd/mem capture, overflow, filter, full push+pop, flush.
module tb_rvfi_trace_capture;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        launch_next_insn = 1'b0;
  logic        trap = 1'b0;
  logic        dbg_valid_insn = 1'b0;
  logic [31:0] dbg_insn_opcode = '0;
  logic [31:0] dbg_insn_addr = '0;
  logic [4:0]  latched_rd = '0;
  logic        irq_state = 1'b0;
  logic        cpuregs_write = 1'b0;
  logic [31:0] cpuregs_wrdata = '0;
  logic        dbg_mem_instr = 1'b0;
  logic        dbg_mem_valid = 1'b0;
  logic        dbg_mem_ready = 1'b0;
  logic [31:0] dbg_mem_addr = '0;
  logic [31:0] dbg_mem_rdata = '0;
  logic [31:0] dbg_mem_wdata = '0;
  logic [3:0]  dbg_mem_wstrb = '0;
  logic        filt_en = 1'b0;
  logic [31:0] filt_lo = '0;
  logic [31:0] filt_hi = '0;
  logic        t_ready = 1'b0;
  logic        t_valid;
  logic [63:0] t_order;
  logic [31:0] t_insn, t_pc;
  logic        t_trap, t_gap;
  logic [4:0]  t_rd_addr;
  logic [31:0] t_rd_wdata, t_mem_addr, t_mem_data;
  logic [3:0]  t_mem_rmask, t_mem_wmask;
  logic [3:0]  level;
  logic        afull;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rvfi_trace_capture dut (
    .clock            (clock),
    .resetn           (resetn),
    .launch_next_insn (launch_next_insn),
    .trap             (trap),
    .dbg_valid_insn   (dbg_valid_insn),
    .dbg_insn_opcode  (dbg_insn_opcode),
    .dbg_insn_addr    (dbg_insn_addr),
    .latched_rd       (latched_rd),
    .irq_state        (irq_state),
    .cpuregs_write    (cpuregs_write),
    .cpuregs_wrdata   (cpuregs_wrdata),
    .dbg_mem_instr    (dbg_mem_instr),
    .dbg_mem_valid    (dbg_mem_valid),
    .dbg_mem_ready    (dbg_mem_ready),
    .dbg_mem_addr     (dbg_mem_addr),
    .dbg_mem_rdata    (dbg_mem_rdata),
    .dbg_mem_wdata    (dbg_mem_wdata),
    .dbg_mem_wstrb    (dbg_mem_wstrb),
    .filt_en          (filt_en),
    .filt_lo          (filt_lo),
    .filt_hi          (filt_hi),
    .t_valid          (t_valid),
    .t_ready          (t_ready),
    .t_order          (t_order),
    .t_insn           (t_insn),
    .t_pc             (t_pc),
    .t_trap           (t_trap),
    .t_gap            (t_gap),
    .t_rd_addr        (t_rd_addr),
    .t_rd_wdata       (t_rd_wdata),
    .t_mem_addr       (t_mem_addr),
    .t_mem_rmask      (t_mem_rmask),
    .t_mem_wmask      (t_mem_wmask),
    .t_mem_data       (t_mem_data),
    .level            (level),
    .afull            (afull),
    .drop_count       (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Retire strobe for one cycle, then one more cycle so it is pushed.
  task automatic retire_one(input logic [31:0] pc,
                            input logic [31:0] insn);
    launch_next_insn = 1'b1;
    dbg_valid_insn   = 1'b1;
    dbg_insn_addr    = pc;
    dbg_insn_opcode  = insn;
    step();
    launch_next_insn = 1'b0;
    dbg_valid_insn   = 1'b0;
    step();
  endtask

  task automatic pop_one();
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_valid", t_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_order", t_order, 0);
    chk("rst_insn", t_insn, 0);
    resetn = 1'b1;
    step();

    // ADDI x5 with rd write
    launch_next_insn = 1'b1;
    dbg_valid_insn   = 1'b1;
    dbg_insn_opcode  = 32'h00A00293;
    dbg_insn_addr    = 32'h100;
    cpuregs_write    = 1'b1;
    latched_rd       = 5'd5;
    cpuregs_wrdata   = 32'h0A;
    step();
    launch_next_insn = 1'b0;
    dbg_valid_insn   = 1'b0;
    cpuregs_write    = 1'b0;
    chk("addi_lat1", t_valid, 0);
    step();
    chk("addi_valid", t_valid, 1);
    chk("addi_order", t_order, 0);
    chk("addi_insn", t_insn, 32'h00A00293);
    chk("addi_pc", t_pc, 32'h100);
    chk("addi_rd", t_rd_addr, 5);
    chk("addi_wdata", t_rd_wdata, 32'h0A);
    chk("addi_rmask", t_mem_rmask, 0);
    chk("addi_wmask", t_mem_wmask, 0);
    chk("addi_level", level, 1);
    pop_one();
    chk("addi_pop", t_valid, 0);

    // SW store capture
    dbg_mem_valid = 1'b1;
    dbg_mem_ready = 1'b1;
    dbg_mem_addr  = 32'h3000_0000;
    dbg_mem_wstrb = 4'hF;
    dbg_mem_wdata = 32'hDEADBEEF;
    dbg_mem_rdata = 32'h11111111;
    step();
    dbg_mem_valid = 1'b0;
    dbg_mem_ready = 1'b0;
    retire_one(32'h104, 32'h00F02023);
    chk("sw_order", t_order, 1);
    chk("sw_addr", t_mem_addr, 32'h3000_0000);
    chk("sw_wmask", t_mem_wmask, 4'hF);
    chk("sw_rmask", t_mem_rmask, 0);
    chk("sw_data", t_mem_data, 32'hDEADBEEF);
    chk("sw_rd", t_rd_addr, 0);
    pop_one();

    // Following retire without an access
    retire_one(32'h108, 32'h00000013);
    chk("nop_order", t_order, 2);
    chk("nop_addr", t_mem_addr, 0);
    chk("nop_wmask", t_mem_wmask, 0);
    chk("nop_rmask", t_mem_rmask, 0);
    chk("nop_data", t_mem_data, 0);
    pop_one();

    // Load capture
    dbg_mem_valid = 1'b1;
    dbg_mem_ready = 1'b1;
    dbg_mem_addr  = 32'h3000_0010;
    dbg_mem_wstrb = 4'h0;
    dbg_mem_wdata = 32'hFFFFFFFF;
    dbg_mem_rdata = 32'h12345678;
    step();
    dbg_mem_valid = 1'b0;
    dbg_mem_ready = 1'b0;
    retire_one(32'h10C, 32'h01002303);
    chk("lw_order", t_order, 3);
    chk("lw_rmask", t_mem_rmask, 4'hF);
    chk("lw_wmask", t_mem_wmask, 0);
    chk("lw_data", t_mem_data, 32'h12345678);
    pop_one();

    // Trap retire
    trap           = 1'b1;
    dbg_valid_insn = 1'b1;
    dbg_insn_addr  = 32'h110;
    step();
    trap           = 1'b0;
    dbg_valid_insn = 1'b0;
    step();
    chk("trap_valid", t_valid, 1);
    chk("trap_flag", t_trap, 1);
    chk("trap_order", t_order, 4);
    pop_one();

    // Overflow with DEPTH=8
    do_reset();
    for (int i = 0; i < 10; i++) begin
      retire_one(32'h400 + 32'(i * 4), 32'h13);
      if (i == 4) chk("ovf_afull5", afull, 0);
      if (i == 5) chk("ovf_afull6", afull, 1);
    end
    chk("ovf_level", level, 8);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_afull", afull, 1);
    t_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_dvalid", t_valid, 1);
      chk("ovf_dorder", t_order, 64'(i));
      chk("ovf_dgap", t_gap, 0);
      step();
    end
    t_ready = 1'b0;
    chk("ovf_empty", level, 0);
    retire_one(32'h500, 32'h13);
    chk("gap_order", t_order, 10);
    chk("gap_flag", t_gap, 1);
    pop_one();
    retire_one(32'h504, 32'h13);
    chk("gap_clr_order", t_order, 11);
    chk("gap_clr", t_gap, 0);
    pop_one();

    // PC window filter
    do_reset();
    filt_en = 1'b1;
    filt_lo = 32'h200;
    filt_hi = 32'h2FF;
    retire_one(32'h1FC, 32'h13);
    retire_one(32'h200, 32'h13);
    retire_one(32'h2FF, 32'h13);
    retire_one(32'h300, 32'h13);
    chk("flt_level", level, 2);
    chk("flt_drop", drop_count, 0);
    chk("flt_pc0", t_pc, 32'h200);
    chk("flt_ord0", t_order, 1);
    pop_one();
    chk("flt_pc1", t_pc, 32'h2FF);
    chk("flt_ord1", t_order, 2);
    pop_one();
    chk("flt_empty", t_valid, 0);
    filt_en = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) retire_one(32'h600 + 32'(i * 4), 32'h13);
    chk("fpp_full", level, 8);
    launch_next_insn = 1'b1;
    dbg_valid_insn   = 1'b1;
    dbg_insn_addr    = 32'h700;
    step();
    launch_next_insn = 1'b0;
    dbg_valid_insn   = 1'b0;
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
    chk("fpp_level", level, 8);
    chk("fpp_drop", drop_count, 0);
    chk("fpp_head", t_order, 5);
    t_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fpp_order", t_order, 64'(5 + i));
      if (i == 7) begin
        chk("fpp_lastpc", t_pc, 32'h700);
        chk("fpp_lastgap", t_gap, 0);
      end
      step();
    end
    t_ready = 1'b0;
    chk("fpp_empty", t_valid, 0);

    // Reset mid-drain with level 5 and a retire in flight
    for (int i = 0; i < 5; i++) retire_one(32'h800 + 32'(i * 4), 32'h13);
    chk("mrst_level5", level, 5);
    launch_next_insn = 1'b1;
    dbg_valid_insn   = 1'b1;
    dbg_insn_addr    = 32'h900;
    step();
    launch_next_insn = 1'b0;
    dbg_valid_insn   = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mrst_valid", t_valid, 0);
    chk("mrst_level", level, 0);
    step();
    step();
    resetn = 1'b1;
    step();
    chk("mrst_noflight", level, 0);
    retire_one(32'hA00, 32'h13);
    chk("mrst_order", t_order, 0);
    chk("mrst_drop", drop_count, 0);
    chk("mrst_lvl1", level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_capture.md
Name: rvfi_trace_capture

Overview:
Parametrised successor to the inline picorv32 debug-to-RVFI glue. It captures the core's debug signals into per-instruction RVFI retire records and assigns each a 64-bit order number. Records pass an optional PC-window filter into a DEPTH-entry FIFO. A valid/ready port drains the FIFO to riscv_debug_bfm or a trace sink. FIFO overflow drops the record, counts it, and flags the gap on the next delivered record.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
AFULL_LEVEL, DEPTH-2, occupancy at or above which afull asserts
MEM_EN, 1, 1 = capture memory fields; 0 = memory fields tied to zero, staging logic removed
DROP_W, 16, width of saturating drop counter

Ports:
clock  in  1  core clock
resetn  in  1  asynchronous active-low reset
launch_next_insn  in  1  core retire strobe
trap  in  1  core trap
dbg_valid_insn  in  1  debug instruction valid
dbg_insn_opcode  in  32  retiring opcode
dbg_insn_addr  in  32  retiring PC
latched_rd  in  5  destination register
irq_state  in  1  core in IRQ entry sequence
cpuregs_write  in  1  register-file write strobe
cpuregs_wrdata  in  32  register-file write data
dbg_mem_instr  in  1  current access is an instruction fetch
dbg_mem_valid, dbg_mem_ready  in  1 each  memory handshake
dbg_mem_addr, dbg_mem_rdata, dbg_mem_wdata  in  32 each  memory bus
dbg_mem_wstrb  in  4  write strobes
filt_en  in  1  enable PC window filter
filt_lo, filt_hi  in  32 each  inclusive PC window
t_valid  out  1  record available
t_ready  in  1  sink accepts
t_order  out  64  retire order number
t_insn, t_pc  out  32 each  opcode, PC
t_trap  out  1  record caused by trap
t_gap  out  1  one or more records dropped before this one
t_rd_addr  out  5  destination register (0 if none)
t_rd_wdata  out  32  rd write data (0 if rd==0)
t_mem_addr  out  32  memory address
t_mem_rmask, t_mem_wmask  out  4 each  read / write byte masks
t_mem_data  out  32  wdata if wmask!=0, else rdata
level  out  $clog2(DEPTH)+1  FIFO occupancy
afull  out  1  level >= AFULL_LEVEL
drop_count  out  DROP_W  saturating count of dropped records

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - t_valid=0, level=0, afull=0, drop_count=0.
  - Order counter = 0, gap flag = 0.
  - All staging registers = 0; t_* data outputs = 0.
- Stage 1, every posedge:
  - ret1 <= resetn & (launch_next_insn | trap) & dbg_valid_insn.
  - Latch trap, opcode and PC alongside ret1.
- rd staging:
  - On cpuregs_write & !irq_state: rd_addr <= latched_rd.
  - rd_wdata <= latched_rd ? cpuregs_wrdata : 0.
- mem staging (MEM_EN=1):
  - dbg_mem_instr clears all mem fields; it has priority.
  - Else on dbg_mem_valid & dbg_mem_ready: capture addr, wmask=wstrb, rmask = (wstrb!=0) ? 0 : 4'hF, rdata, wdata.
- Record formation:
  - When ret1=1, the record is assembled from stage-1 and staging registers in that same cycle.
  - Order = counter; counter increments by 1 on every retire, including filtered or dropped records.
  - rd and mem staging clear to 0 in the cycle after formation, unless a new capture occurs that cycle; the capture wins.
- Filter:
  - filt_en=1 and (pc < filt_lo or pc > filt_hi) -> record discarded silently.
  - A filtered record is not a drop and does not change the gap flag.
- Push:
  - Record enters the FIFO in the formation cycle.
  - Latency: retire strobe to t_valid = 2 clocks when the FIFO was empty.
- Overflow:
  - Push while level==DEPTH and no pop that cycle -> record dropped, drop_count++ (saturates at all-ones), gap flag set.
  - The next accepted record carries t_gap=1; the gap flag clears on that push.
- Simultaneous push and pop when full: both take effect, no drop, level unchanged.
- Output port: first-word-fall-through. t_* are stable while t_valid & !t_ready; a pop happens on t_valid & t_ready.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- Reset mid-operation flushes the FIFO, discards in-flight ret1, and zeroes order and drop_count.

Decomposition:
- Package rvfi_trace_pkg:
  - rvfi_rec_t packed struct (order, insn, pc, trap, gap, rd_addr, rd_wdata, mem_addr, rmask, wmask, mem_data).
  - ORDER_W=64 constant.
- Sub-module rvfi_trace_fifo: parametrised synchronous FIFO of rvfi_rec_t with level output and FWFT read.

Test Plan:
- Single retire of ADDI x5 (opcode 0x00A00293, pc 0x100) with cpuregs_write, wrdata=0x0A -> two clocks later t_valid=1, order=0, rd_addr=5, rd_wdata=0x0A, masks 0.
- SW to 0x3000_0000, wstrb=4'hF, wdata=0xDEADBEEF, then a retire -> wmask=F, rmask=0, t_mem_data=0xDEADBEEF. A following retire with no access -> mem_addr=0, masks 0.
- DEPTH=8, t_ready=0, 10 retires -> level=8, afull from level 6, drop_count=2. Release t_ready -> orders 0..7 with t_gap=0. Next retire -> order 10, t_gap=1.
- filt_en=1, window 0x200..0x2FF, retires at 0x1FC, 0x200, 0x2FF, 0x300 -> only PCs 0x200 and 0x2FF emitted, with orders 1 and 2; drop_count stays 0.
- Full FIFO, t_ready=1 and a retire in the same cycle -> no drop, level stays 8, pushed record appears in order.
- Assert resetn low mid-drain with level=5 -> t_valid=0 and level=0 immediately. After release, the first retire gets order 0.
